// File: rtl/mem_access_unit_pkg.sv
// rtl/mem_access_unit_pkg.sv - MEM-stage op codes, exception masks, FSM states and alignment helpers
package mem_access_unit_pkg;

    localparam logic [3:0] MEM_NOP = 4'd0;
    localparam logic [3:0] MEM_LB  = 4'd1;
    localparam logic [3:0] MEM_LH  = 4'd2;
    localparam logic [3:0] MEM_LW  = 4'd3;
    localparam logic [3:0] MEM_LBU = 4'd4;
    localparam logic [3:0] MEM_LHU = 4'd5;
    localparam logic [3:0] MEM_SB  = 4'd6;
    localparam logic [3:0] MEM_SH  = 4'd7;
    localparam logic [3:0] MEM_SW  = 4'd8;

    localparam logic [31:0] EXC_LOAD_MISALIGN  = 32'h0000_0010;
    localparam logic [31:0] EXC_LOAD_FAULT     = 32'h0000_0020;
    localparam logic [31:0] EXC_STORE_MISALIGN = 32'h0000_0040;
    localparam logic [31:0] EXC_STORE_FAULT    = 32'h0000_0080;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } mau_state_e;

    function automatic logic is_store(input logic [3:0] op);
        return (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
    endfunction

    function automatic logic is_half(input logic [3:0] op);
        return (op == MEM_LH) || (op == MEM_LHU) || (op == MEM_SH);
    endfunction

    function automatic logic is_word(input logic [3:0] op);
        return (op == MEM_LW) || (op == MEM_SW);
    endfunction

    function automatic logic misaligned(input logic [3:0] op, input logic [1:0] off);
        return (is_half(op) && off[0]) || (is_word(op) && (off != 2'b00));
    endfunction

    // Byte offset after forcing the access down to its natural alignment.
    function automatic logic [1:0] align_off(input logic [3:0] op, input logic [1:0] off);
        if (is_word(op))
            return 2'b00;
        else if (is_half(op))
            return {off[1], 1'b0};
        else
            return off;
    endfunction

endpackage

// File: rtl/mem_lane_fmt.sv
// rtl/mem_lane_fmt.sv - byte-enable/store-lane generation and load extract/extend (combinational)
module mem_lane_fmt
    import mem_access_unit_pkg::*;
(
    input  logic [3:0]  i_req_op,
    input  logic [1:0]  i_req_off,
    input  logic [31:0] i_st_data,
    input  logic [3:0]  i_ld_op,
    input  logic [1:0]  i_ld_off,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_ldata
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        o_be    = 4'b0000;
        o_wdata = 32'h0;
        case (i_req_op)
            MEM_LB, MEM_LBU, MEM_SB: begin
                o_be    = 4'b0001 << i_req_off;
                o_wdata = {4{i_st_data[7:0]}};
            end
            MEM_LH, MEM_LHU, MEM_SH: begin
                o_be    = i_req_off[1] ? 4'b1100 : 4'b0011;
                o_wdata = {2{i_st_data[15:0]}};
            end
            MEM_LW, MEM_SW: begin
                o_be    = 4'b1111;
                o_wdata = i_st_data;
            end
            default: ;
        endcase
        if (!is_store(i_req_op))
            o_wdata = 32'h0;
    end

    always_comb begin
        w_byte  = i_rdata[{i_ld_off, 3'b000} +: 8];
        w_half  = i_ld_off[1] ? i_rdata[31:16] : i_rdata[15:0];
        o_ldata = i_rdata;
        case (i_ld_op)
            MEM_LB:  o_ldata = {{24{w_byte[7]}}, w_byte};
            MEM_LBU: o_ldata = {24'h0, w_byte};
            MEM_LH:  o_ldata = {{16{w_half[15]}}, w_half};
            MEM_LHU: o_ldata = {16'h0, w_half};
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM-stage load/store engine on a req/ack data bus with timeout and flush handling
// MEM_MISALIGN_EXC_EN: when defined, misaligned LH/LHU/SH/LW/SW raise an exception instead of being force-aligned.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [4:0]  reg_waddr_i,
    input  logic        reg_we_i,
    input  logic [31:0] reg_wdata_i,
    input  logic        mem_we_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_data_i,
    input  logic [3:0]  mem_op_i,
    input  logic [31:0] exception_i,
    input  logic        flush_int_i,
    output logic        dbus_req_o,
    output logic        dbus_we_o,
    output logic [31:0] dbus_addr_o,
    output logic [3:0]  dbus_be_o,
    output logic [31:0] dbus_wdata_o,
    input  logic        dbus_ack_i,
    input  logic [31:0] dbus_rdata_i,
    input  logic        dbus_err_i,
    output logic [4:0]  reg_waddr_o,
    output logic        reg_we_o,
    output logic [31:0] reg_wdata_o,
    output logic [31:0] exception_o,
    output logic        stall_req_o
);

    mau_state_e  r_state, w_state_nxt;
    logic [7:0]  r_tmo_cnt;
    logic [31:0] r_load_q;
    logic        r_fault_q, r_flush_pend;
    logic [3:0]  r_op;
    logic [1:0]  r_off;

    logic        w_is_mem, w_misalign, w_access, w_tmo, w_flush, w_store;
    logic [1:0]  w_off;
    logic [3:0]  w_be;
    logic [31:0] w_wdata, w_ldata;

    assign w_is_mem = (mem_op_i != MEM_NOP);
    // Op code decides store vs load; mem_we_i is redundant and only sanity-ORed in.
    assign w_store  = is_store(mem_op_i) | (mem_we_i & is_store(mem_op_i));
    assign w_off    = align_off(mem_op_i, mem_addr_i[1:0]);
`ifdef MEM_MISALIGN_EXC_EN
    assign w_misalign = w_is_mem && misaligned(mem_op_i, mem_addr_i[1:0]);
`else
    assign w_misalign = 1'b0;
`endif
    assign w_access = w_is_mem && (exception_i == 32'h0) && !flush_int_i && !w_misalign;
    assign w_tmo    = (r_tmo_cnt == 8'(TIMEOUT_CYCLES - 1));
    assign w_flush  = r_flush_pend | flush_int_i;

    mem_lane_fmt u_fmt (
        .i_req_op  (mem_op_i),
        .i_req_off (w_off),
        .i_st_data (mem_data_i),
        .i_ld_op   (r_op),
        .i_ld_off  (r_off),
        .i_rdata   (dbus_rdata_i),
        .o_be      (w_be),
        .o_wdata   (w_wdata),
        .o_ldata   (w_ldata)
    );

    always_comb begin
        w_state_nxt = r_state;
        stall_req_o = 1'b0;
        reg_waddr_o = reg_waddr_i;
        reg_we_o    = reg_we_i;
        reg_wdata_o = reg_wdata_i;
        exception_o = exception_i;
        case (r_state)
            ST_IDLE: begin
                if (w_access) begin
                    stall_req_o = 1'b1;
                    reg_we_o    = 1'b0;
                    w_state_nxt = ST_BUSY;
                end else if (w_is_mem && ((exception_i != 32'h0) || w_misalign)) begin
                    reg_we_o = 1'b0;
                end
                if (w_misalign)
                    exception_o = exception_i | (w_store ? EXC_STORE_MISALIGN : EXC_LOAD_MISALIGN);
            end
            ST_BUSY: begin
                stall_req_o = 1'b1;
                reg_we_o    = 1'b0;
                // A flushed transaction still completes on the bus but never reaches DONE.
                if (dbus_ack_i || w_tmo)
                    w_state_nxt = w_flush ? ST_IDLE : ST_DONE;
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
                if (!dbus_we_o)
                    reg_wdata_o = r_load_q;
                reg_we_o = reg_we_i & ~r_fault_q;
                if (r_fault_q)
                    exception_o = exception_i | (dbus_we_o ? EXC_STORE_FAULT : EXC_LOAD_FAULT);
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state      <= ST_IDLE;
            dbus_req_o   <= 1'b0;
            dbus_we_o    <= 1'b0;
            dbus_addr_o  <= 32'h0;
            dbus_be_o    <= 4'h0;
            dbus_wdata_o <= 32'h0;
            r_load_q     <= 32'h0;
            r_fault_q    <= 1'b0;
            r_flush_pend <= 1'b0;
            r_tmo_cnt    <= 8'h0;
            r_op         <= MEM_NOP;
            r_off        <= 2'b00;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                ST_IDLE: begin
                    if (w_access) begin
                        dbus_req_o   <= 1'b1;
                        dbus_we_o    <= w_store;
                        dbus_addr_o  <= {mem_addr_i[31:2], 2'b00};
                        dbus_be_o    <= w_be;
                        dbus_wdata_o <= w_wdata;
                        r_op         <= mem_op_i;
                        r_off        <= w_off;
                        r_tmo_cnt    <= 8'h0;
                        r_fault_q    <= 1'b0;
                        r_flush_pend <= 1'b0;
                    end
                end
                ST_BUSY: begin
                    r_tmo_cnt <= r_tmo_cnt + 8'h1;
                    if (flush_int_i)
                        r_flush_pend <= 1'b1;
                    if (dbus_ack_i) begin
                        dbus_req_o <= 1'b0;
                        r_load_q   <= w_ldata;
                        r_fault_q  <= dbus_err_i;
                    end else if (w_tmo) begin
                        dbus_req_o <= 1'b0;
                        r_fault_q  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed self-checking bench for mem_access_unit with a behavioural access model
module tb_mem_access_unit;
    import mem_access_unit_pkg::*;

    localparam int TMO = 255;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  reg_waddr_i;
    logic        reg_we_i;
    logic [31:0] reg_wdata_i;
    logic        mem_we_i;
    logic [31:0] mem_addr_i;
    logic [31:0] mem_data_i;
    logic [3:0]  mem_op_i;
    logic [31:0] exception_i;
    logic        flush_int_i;
    logic        dbus_req_o, dbus_we_o;
    logic [31:0] dbus_addr_o, dbus_wdata_o;
    logic [3:0]  dbus_be_o;
    logic        dbus_ack_i, dbus_err_i;
    logic [31:0] dbus_rdata_i;
    logic [4:0]  reg_waddr_o;
    logic        reg_we_o;
    logic [31:0] reg_wdata_o, exception_o;
    logic        stall_req_o;

    int n_chk = 0;
    int n_fail = 0;

    logic        e_on = 1'b0, e_stall, e_req, e_we, e_wb_on, e_rwe;
    logic [31:0] e_addr, e_wdata, e_rwdata, e_exc;
    logic [3:0]  e_be;
    logic [4:0]  e_waddr;

    always #5 clk = ~clk;

    mem_access_unit #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk_i(clk), .rst_i(rst),
        .reg_waddr_i(reg_waddr_i), .reg_we_i(reg_we_i), .reg_wdata_i(reg_wdata_i),
        .mem_we_i(mem_we_i), .mem_addr_i(mem_addr_i), .mem_data_i(mem_data_i),
        .mem_op_i(mem_op_i), .exception_i(exception_i), .flush_int_i(flush_int_i),
        .dbus_req_o(dbus_req_o), .dbus_we_o(dbus_we_o), .dbus_addr_o(dbus_addr_o),
        .dbus_be_o(dbus_be_o), .dbus_wdata_o(dbus_wdata_o),
        .dbus_ack_i(dbus_ack_i), .dbus_rdata_i(dbus_rdata_i), .dbus_err_i(dbus_err_i),
        .reg_waddr_o(reg_waddr_o), .reg_we_o(reg_we_o), .reg_wdata_o(reg_wdata_o),
        .exception_o(exception_o), .stall_req_o(stall_req_o)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: access size, naturally aligned offset, lanes, extracted load value.
    function automatic int msize(input logic [3:0] op);
        case (op)
            MEM_LB, MEM_LBU, MEM_SB: return 1;
            MEM_LH, MEM_LHU, MEM_SH: return 2;
            default:                 return 4;
        endcase
    endfunction

    function automatic logic mstore(input logic [3:0] op);
        return (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
    endfunction

    function automatic int moff(input logic [3:0] op, input logic [31:0] a);
        int s = msize(op);
        return (int'(a % 4) / s) * s;
    endfunction

    function automatic logic [3:0] mbe(input logic [3:0] op, input logic [31:0] a);
        int s = msize(op);
        return 4'(((1 << s) - 1) << moff(op, a));
    endfunction

    function automatic logic [31:0] mwdata(input logic [3:0] op, input logic [31:0] d);
        case (msize(op))
            1:       return (d & 32'hFF) * 32'h0101_0101;
            2:       return (d & 32'hFFFF) * 32'h0001_0001;
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] mload(input logic [3:0] op, input logic [31:0] a, input logic [31:0] rd);
        int s = msize(op);
        logic [31:0] mask, v;
        mask = (s == 4) ? 32'hFFFF_FFFF : 32'((1 << (8 * s)) - 1);
        v = (rd >> (8 * moff(op, a))) & mask;
        if ((op == MEM_LB || op == MEM_LH) && v[8 * s - 1])
            v = v | ~mask;
        return v;
    endfunction

    function automatic logic mmis(input logic [3:0] op, input logic [31:0] a);
`ifdef MEM_MISALIGN_EXC_EN
        return (op != MEM_NOP) && ((a % 32'(msize(op))) != 0);
`else
        return (op == MEM_NOP) && (a === 32'hx);
`endif
    endfunction

    always @(negedge clk) begin
        if (e_on) begin
            chk("stall", 32'(stall_req_o), 32'(e_stall));
            chk("req", 32'(dbus_req_o), 32'(e_req));
            if (e_req) begin
                chk("bus_addr", dbus_addr_o, e_addr);
                chk("bus_be", 32'(dbus_be_o), 32'(e_be));
                chk("bus_we", 32'(dbus_we_o), 32'(e_we));
                if (e_we)
                    chk("bus_wdata", dbus_wdata_o, e_wdata);
            end
            if (e_wb_on) begin
                chk("wb_we", 32'(reg_we_o), 32'(e_rwe));
                chk("wb_waddr", 32'(reg_waddr_o), 32'(e_waddr));
                chk("wb_exc", exception_o, e_exc);
                if (e_rwe)
                    chk("wb_wdata", reg_wdata_o, e_rwdata);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        mem_op_i = MEM_NOP; mem_we_i = 1'b0; reg_we_i = 1'b0; exception_i = 32'h0; flush_int_i = 1'b0;
        e_on = 1'b1; e_stall = 1'b0; e_req = 1'b0; e_wb_on = 1'b1;
        e_rwe = 1'b0; e_waddr = reg_waddr_i; e_exc = 32'h0;
        cyc();
    endtask

    // One access: IDLE cycle, BUSY cycles (ack in BUSY cycle ack_dly, 0 = never), then DONE or flushed exit.
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] rdata, input int ack_dly, input logic err,
                          input int flush_at, input logic we_in, input logic lit_en,
                          input logic [3:0] lit_be, input logic [31:0] lit_wdata,
                          input logic [31:0] lit_wb, input logic [31:0] lit_exc);
        logic st = mstore(op);
        logic fault = err || (ack_dly == 0);
        int   n = (ack_dly == 0) ? TMO : ack_dly;
        logic [31:0] alu = 32'hA1A1_0000 ^ a;
        mem_op_i = op; mem_we_i = st; mem_addr_i = a; mem_data_i = d;
        reg_waddr_i = 5'd7; reg_we_i = we_in; reg_wdata_i = alu;
        exception_i = 32'h0; flush_int_i = 1'b0; dbus_ack_i = 1'b0; dbus_err_i = 1'b0;
        e_on = 1'b1; e_stall = 1'b1; e_req = 1'b0; e_wb_on = 1'b0;
        cyc();
        for (int k = 1; k <= n; k++) begin
            e_stall = 1'b1; e_req = 1'b1; e_addr = a & ~32'h3; e_be = mbe(op, a);
            e_we = st; e_wdata = mwdata(op, d);
            flush_int_i = (k == flush_at);
            if (k == ack_dly) begin
                dbus_ack_i = 1'b1; dbus_rdata_i = rdata; dbus_err_i = err;
            end
            if (k == 1 && lit_en) begin
                @(negedge clk);
                chk("lit_be", 32'(dbus_be_o), 32'(lit_be));
                if (st)
                    chk("lit_wdata", dbus_wdata_o, lit_wdata);
            end
            cyc();
            dbus_ack_i = 1'b0; dbus_err_i = 1'b0; flush_int_i = 1'b0;
        end
        e_req = 1'b0; e_stall = 1'b0; e_wb_on = 1'b1; e_waddr = 5'd7;
        if (flush_at != 0) begin
            mem_op_i = MEM_NOP; reg_we_i = 1'b1; reg_wdata_i = 32'h5A5A_0001;
            e_rwe = 1'b1; e_rwdata = 32'h5A5A_0001; e_exc = 32'h0;
            cyc();
        end else begin
            e_rwe = we_in & ~fault;
            e_rwdata = st ? alu : mload(op, a, rdata);
            e_exc = fault ? (st ? EXC_STORE_FAULT : EXC_LOAD_FAULT) : 32'h0;
            if (lit_en) begin
                @(negedge clk);
                if (we_in & ~fault)
                    chk("lit_wb", reg_wdata_o, lit_wb);
                chk("lit_exc", exception_o, lit_exc);
            end
            cyc();
        end
        idle();
    endtask

    // Single IDLE cycle where no bus access may start (exception, flush or misalignment).
    task automatic pass_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] exc,
                           input logic flush, input logic [31:0] lit_exc);
        logic kill;
        mem_op_i = op; mem_we_i = mstore(op); mem_addr_i = a; mem_data_i = 32'h1;
        reg_waddr_i = 5'd9; reg_we_i = 1'b1; reg_wdata_i = 32'h0BAD_F00D;
        exception_i = exc; flush_int_i = flush;
        kill = (op != MEM_NOP) && ((exc != 32'h0) || mmis(op, a));
        e_on = 1'b1; e_stall = 1'b0; e_req = 1'b0; e_wb_on = 1'b1;
        e_rwe = ~kill; e_waddr = 5'd9; e_rwdata = 32'h0BAD_F00D;
        e_exc = exc | (mmis(op, a) ? (mstore(op) ? EXC_STORE_MISALIGN : EXC_LOAD_MISALIGN) : 32'h0);
        @(negedge clk);
        chk("lit_pass_exc", exception_o, lit_exc);
        cyc();
        idle();
    endtask

    initial begin
        rst = 1'b1;
        reg_waddr_i = 5'd0; reg_we_i = 1'b0; reg_wdata_i = 32'h0; mem_we_i = 1'b0;
        mem_addr_i = 32'h0; mem_data_i = 32'h0; mem_op_i = MEM_NOP; exception_i = 32'h0;
        flush_int_i = 1'b0; dbus_ack_i = 1'b0; dbus_rdata_i = 32'h0; dbus_err_i = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req", 32'(dbus_req_o), 32'h0);
        chk("rst_we", 32'(dbus_we_o), 32'h0);
        chk("rst_addr", dbus_addr_o, 32'h0);
        chk("rst_be", 32'(dbus_be_o), 32'h0);
        chk("rst_wdata", dbus_wdata_o, 32'h0);
        chk("rst_stall", 32'(stall_req_o), 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        idle();

        run_op(MEM_SW,  32'h100, 32'h1234_5678, 32'h0,         2, 1'b0, 0, 1'b0,
               1'b1, 4'hF, 32'h1234_5678, 32'h0, 32'h0);
        run_op(MEM_LB,  32'h103, 32'h0,         32'h80FF_0000, 1, 1'b0, 0, 1'b1,
               1'b1, 4'h8, 32'h0, 32'hFFFF_FF80, 32'h0);
        run_op(MEM_LBU, 32'h103, 32'h0,         32'h80FF_0000, 3, 1'b0, 0, 1'b1,
               1'b1, 4'h8, 32'h0, 32'h0000_0080, 32'h0);
        run_op(MEM_SH,  32'h102, 32'h0000_ABCD, 32'h0,         1, 1'b0, 0, 1'b1,
               1'b1, 4'hC, 32'hABCD_ABCD, 32'hA1A1_0102, 32'h0);
        run_op(MEM_LHU, 32'h102, 32'h0,         32'hBEEF_1234, 1, 1'b0, 0, 1'b1,
               1'b1, 4'hC, 32'h0, 32'h0000_BEEF, 32'h0);
        run_op(MEM_LH,  32'h100, 32'h0,         32'h0000_8001, 2, 1'b0, 0, 1'b1,
               1'b1, 4'h3, 32'h0, 32'hFFFF_8001, 32'h0);
        run_op(MEM_SB,  32'h101, 32'h0000_0077, 32'h0,         1, 1'b0, 0, 1'b0,
               1'b1, 4'h2, 32'h7777_7777, 32'h0, 32'h0);
        run_op(MEM_LW,  32'h108, 32'h0,         32'hDEAD_BEEF, 2, 1'b1, 0, 1'b1,
               1'b1, 4'hF, 32'h0, 32'h0, EXC_LOAD_FAULT);
        run_op(MEM_SW,  32'h10C, 32'h0000_0055, 32'h0,         1, 1'b1, 0, 1'b0,
               1'b1, 4'hF, 32'h0000_0055, 32'h0, EXC_STORE_FAULT);
        run_op(MEM_LW,  32'h110, 32'h0,         32'h0,         0, 1'b0, 0, 1'b1,
               1'b1, 4'hF, 32'h0, 32'h0, EXC_LOAD_FAULT);
        run_op(MEM_LW,  32'h114, 32'h0,         32'h1111_2222, 6, 1'b0, 2, 1'b1,
               1'b0, 4'h0, 32'h0, 32'h0, 32'h0);
        run_op(MEM_LW,  32'h118, 32'h0,         32'h3333_4444, 1, 1'b0, 0, 1'b1,
               1'b1, 4'hF, 32'h0, 32'h3333_4444, 32'h0);

        pass_op(MEM_LW, 32'h120, 32'h0000_0004, 1'b0, 32'h0000_0004);
        pass_op(MEM_SW, 32'h124, 32'h0,         1'b1, 32'h0);
`ifdef MEM_MISALIGN_EXC_EN
        pass_op(MEM_LW, 32'h101, 32'h0,         1'b0, EXC_LOAD_MISALIGN);
        pass_op(MEM_SH, 32'h103, 32'h0,         1'b0, EXC_STORE_MISALIGN);
`else
        run_op(MEM_LW,  32'h101, 32'h0,         32'hCAFE_F00D, 1, 1'b0, 0, 1'b1,
               1'b1, 4'hF, 32'h0, 32'hCAFE_F00D, 32'h0);
        run_op(MEM_LHU, 32'h103, 32'h0,         32'hCAFE_F00D, 1, 1'b0, 0, 1'b1,
               1'b1, 4'hC, 32'h0, 32'h0000_CAFE, 32'h0);
`endif

        mem_op_i = MEM_LW; mem_we_i = 1'b0; mem_addr_i = 32'h200; reg_we_i = 1'b1;
        e_on = 1'b1; e_stall = 1'b1; e_req = 1'b0; e_wb_on = 1'b0;
        cyc();
        e_req = 1'b1; e_addr = 32'h200; e_be = 4'hF; e_we = 1'b0;
        @(negedge clk);
        #2;
        e_on = 1'b0; mem_op_i = MEM_NOP; rst = 1'b1;
        #1;
        chk("rst_busy_req", 32'(dbus_req_o), 32'h0);
        chk("rst_busy_stall", 32'(stall_req_o), 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        idle();
        run_op(MEM_SB,  32'h203, 32'h0000_00A5, 32'h0,         1, 1'b0, 0, 1'b0,
               1'b1, 4'h8, 32'hA5A5_A5A5, 32'h0, 32'h0);

        e_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
